// File: rtl/m2_pkg.sv
// Shared types and constants for the milestone-2 block I/O engine.
package m2_pkg;

    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned RAM_AW  = 6;
    localparam int unsigned RAM_DW  = 32;
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned COL_W   = 6;

    localparam int unsigned PLANE_W_Y  = 320;
    localparam int unsigned PLANE_W_UV = 160;

    localparam int unsigned SEG_Y_BASE        = 0;
    localparam int unsigned SEG_U_BASE        = 38400;
    localparam int unsigned SEG_V_BASE        = 57600;
    localparam int unsigned SEG_PRE_IDCT_BASE = 76800;
    localparam int unsigned PRE_IDCT_OFF_U    = 76800;
    localparam int unsigned PRE_IDCT_OFF_V    = 115200;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FETCH_ISSUE = 3'd1,
        S_FETCH_DRAIN = 3'd2,
        S_WB_RUN      = 3'd3,
        S_DONE        = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PLANE_Y = 2'd0,
        PLANE_U = 2'd1,
        PLANE_V = 2'd2
    } plane_t;

    typedef struct packed {
        logic             wb;
        plane_t           plane;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } cmd_t;

    // Saturate a signed IDCT result into an unsigned 8-bit pixel.
    function automatic logic [7:0] clip8(input logic signed [RAM_DW-1:0] v);
        logic [7:0] r;
        if (v < 0)
            r = 8'd0;
        else if (v > 255)
            r = 8'hFF;
        else
            r = v[7:0];
        return r;
    endfunction

endpackage

// File: rtl/m2_block_io_if.sv
// SRAM and dual-port RAM bus between the block I/O engine and the memories.
interface m2_block_io_if;
    import m2_pkg::*;

    logic [SRAM_AW-1:0] SRAM_address;
    logic [SRAM_DW-1:0] SRAM_write_data;
    logic               SRAM_we_n;
    logic [SRAM_DW-1:0] SRAM_read_data;
    logic [RAM_AW-1:0]  ram_address;
    logic [SRAM_DW-1:0] ram_write_data;
    logic               ram_we;
    logic [RAM_DW-1:0]  ram_read_data;

    modport master (
        output SRAM_address, SRAM_write_data, SRAM_we_n,
        output ram_address, ram_write_data, ram_we,
        input  SRAM_read_data, ram_read_data
    );

    modport slave (
        input  SRAM_address, SRAM_write_data, SRAM_we_n,
        input  ram_address, ram_write_data, ram_we,
        output SRAM_read_data, ram_read_data
    );
endinterface

// File: rtl/m2_addr_gen.sv
// Combinational SRAM word-address generator for fetch and writeback.
module m2_addr_gen
    import m2_pkg::*;
#(
    parameter int unsigned Y_BASE        = SEG_Y_BASE,
    parameter int unsigned U_BASE        = SEG_U_BASE,
    parameter int unsigned V_BASE        = SEG_V_BASE,
    parameter int unsigned PRE_IDCT_BASE = SEG_PRE_IDCT_BASE
) (
    input  logic               wb,
    input  plane_t             plane,
    input  logic [ROW_W-1:0]   block_row,
    input  logic [COL_W-1:0]   block_col,
    input  logic [RAM_AW-1:0]  k,
    output logic [SRAM_AW-1:0] addr_c
);

    logic [7:0]         line;
    logic [SRAM_AW-1:0] width;
    logic [SRAM_AW-1:0] base;
    logic [SRAM_AW-1:0] col_off;

    // Line-major address: base + line*stride + column offset; writeback packs two pixels per word.
    always_comb begin
        line  = {block_row, k[5:3]};
        width = (plane == PLANE_Y) ? SRAM_AW'(PLANE_W_Y) : SRAM_AW'(PLANE_W_UV);
        if (wb) begin
            case (plane)
                PLANE_U: base = SRAM_AW'(U_BASE);
                PLANE_V: base = SRAM_AW'(V_BASE);
                default: base = SRAM_AW'(Y_BASE);
            endcase
            width   = width >> 1;
            col_off = SRAM_AW'({block_col, 2'b00}) + SRAM_AW'(k[2:1]);
        end else begin
            case (plane)
                PLANE_U: base = SRAM_AW'(PRE_IDCT_BASE + PRE_IDCT_OFF_U);
                PLANE_V: base = SRAM_AW'(PRE_IDCT_BASE + PRE_IDCT_OFF_V);
                default: base = SRAM_AW'(PRE_IDCT_BASE);
            endcase
            col_off = SRAM_AW'({block_col, 3'b000}) + SRAM_AW'(k[2:0]);
        end
        addr_c = base + SRAM_AW'(SRAM_AW'(line) * width) + col_off;
    end

endmodule

// File: rtl/m2_block_io.sv
// Fetches one 8x8 pre-IDCT block into the DP-RAM, or clips/packs IDCT results back to SRAM.
module m2_block_io
    import m2_pkg::*;
#(
    parameter int unsigned READ_LATENCY  = 3,
    parameter int unsigned Y_BASE        = SEG_Y_BASE,
    parameter int unsigned U_BASE        = SEG_U_BASE,
    parameter int unsigned V_BASE        = SEG_V_BASE,
    parameter int unsigned PRE_IDCT_BASE = SEG_PRE_IDCT_BASE
) (
    input  logic             CLOCK_50_I,
    input  logic             resetn,
    input  logic             start,
    input  logic             cmd_writeback,
    input  logic [1:0]       plane,
    input  logic [ROW_W-1:0] block_row,
    input  logic [COL_W-1:0] block_col,
    output logic             busy,
    output logic             done,
    m2_block_io_if.master    mem
);

    localparam logic [RAM_AW-1:0] K_LAST = RAM_AW'(63);

    state_t                               state_q, state_d;
    cmd_t                                 cmd_q, cmd_d;
    logic [RAM_AW-1:0]                    k_q, k_d;
    logic                                 iss_q, iss_d;
    logic                                 busy_q, busy_d;
    logic                                 done_q, done_d;
    logic [READ_LATENCY-1:0]              rd_vld_q, rd_vld_d;
    logic [READ_LATENCY-1:0][RAM_AW-1:0]  rd_k_q, rd_k_d;
    logic                                 wb_vld_q, wb_vld_d;
    logic [RAM_AW-1:0]                    wb_k_q, wb_k_d;
    logic [7:0]                           hi_q, hi_d;
    logic                                 last_wr_q, last_wr_d;
    logic [SRAM_AW-1:0]                   sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0]                   sram_wdata_q, sram_wdata_d;
    logic                                 sram_we_n_q, sram_we_n_d;
    logic [RAM_AW-1:0]                    ram_addr_q, ram_addr_d;
    logic                                 ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]                    gen_k_c;
    logic [SRAM_AW-1:0]                   gen_addr_c;
    logic [7:0]                           pix_c;

    // Fetch addresses the next issue index; writeback addresses the sample returning from RAM.
    assign gen_k_c = cmd_d.wb ? wb_k_q : k_d;
    assign pix_c   = clip8($signed(mem.ram_read_data));

    m2_addr_gen #(
        .Y_BASE        (Y_BASE),
        .U_BASE        (U_BASE),
        .V_BASE        (V_BASE),
        .PRE_IDCT_BASE (PRE_IDCT_BASE)
    ) u_addr_gen (
        .wb        (cmd_d.wb),
        .plane     (cmd_d.plane),
        .block_row (cmd_d.row),
        .block_col (cmd_d.col),
        .k         (gen_k_c),
        .addr_c    (gen_addr_c)
    );

    // Next-state, command capture and issue-index sequencing.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        k_d     = k_q;
        iss_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d.wb    = cmd_writeback;
                    cmd_d.plane = (plane == 2'd3) ? PLANE_Y : plane_t'(plane);
                    cmd_d.row   = block_row;
                    cmd_d.col   = block_col;
                    k_d         = '0;
                    iss_d       = 1'b1;
                    state_d     = cmd_writeback ? S_WB_RUN : S_FETCH_ISSUE;
                end
            end
            S_FETCH_ISSUE: begin
                if (k_q == K_LAST) begin
                    state_d = S_FETCH_DRAIN;
                end else begin
                    k_d   = k_q + RAM_AW'(1);
                    iss_d = 1'b1;
                end
            end
            S_FETCH_DRAIN: begin
                if (ram_we_q && ram_addr_q == K_LAST)
                    state_d = S_DONE;
            end
            S_WB_RUN: begin
                if (iss_q && k_q != K_LAST) begin
                    k_d   = k_q + RAM_AW'(1);
                    iss_d = 1'b1;
                end
                if (last_wr_q)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Datapath: SRAM read pipeline into RAM writes, and RAM reads clipped/packed into SRAM writes.
    always_comb begin
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_n_d  = 1'b1;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        hi_d         = hi_q;
        last_wr_d    = 1'b0;
        wb_vld_d     = iss_q & cmd_q.wb;
        wb_k_d       = k_q;
        rd_vld_d     = '0;
        rd_k_d       = '0;
        rd_vld_d[0]  = iss_d & ~cmd_d.wb;
        rd_k_d[0]    = k_d;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_k_d[i]   = rd_k_q[i-1];
        end
        if (iss_d) begin
            if (cmd_d.wb)
                ram_addr_d = k_d;
            else
                sram_addr_d = gen_addr_c;
        end
        if (rd_vld_q[READ_LATENCY-1]) begin
            ram_we_d   = 1'b1;
            ram_addr_d = rd_k_q[READ_LATENCY-1];
        end
        if (wb_vld_q) begin
            if (!wb_k_q[0]) begin
                hi_d = pix_c;
            end else begin
                sram_we_n_d  = 1'b0;
                sram_wdata_d = {hi_q, pix_c};
                sram_addr_d  = gen_addr_c;
                last_wr_d    = (wb_k_q == K_LAST);
            end
        end
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            k_q          <= '0;
            iss_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_vld_q     <= '0;
            rd_k_q       <= '0;
            wb_vld_q     <= 1'b0;
            wb_k_q       <= '0;
            hi_q         <= '0;
            last_wr_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_n_q  <= 1'b1;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            k_q          <= k_d;
            iss_q        <= iss_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_vld_q     <= rd_vld_d;
            rd_k_q       <= rd_k_d;
            wb_vld_q     <= wb_vld_d;
            wb_k_q       <= wb_k_d;
            hi_q         <= hi_d;
            last_wr_q    <= last_wr_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign mem.SRAM_address    = sram_addr_q;
    assign mem.SRAM_write_data = sram_wdata_q;
    assign mem.SRAM_we_n       = sram_we_n_q;
    assign mem.ram_address     = ram_addr_q;
    assign mem.ram_we          = ram_we_q;
    // Read data lands in the RAM in the same cycle it leaves the SRAM; zero when not writing.
    assign mem.ram_write_data  = ram_we_q ? mem.SRAM_read_data : '0;

endmodule

// File: tb/tb_m2_block_io.sv
// Randomised self-checking bench for m2_block_io against a formula-level reference model.
module tb_m2_block_io;
    import m2_pkg::*;

    logic       CLOCK_50_I = 1'b0;
    logic       resetn;
    logic       start;
    logic       cmd_writeback;
    logic [1:0] plane;
    logic [4:0] block_row;
    logic [5:0] block_col;
    logic       busy;
    logic       done;

    m2_block_io_if mif();

    m2_block_io dut (
        .CLOCK_50_I    (CLOCK_50_I),
        .resetn        (resetn),
        .start         (start),
        .cmd_writeback (cmd_writeback),
        .plane         (plane),
        .block_row     (block_row),
        .block_col     (block_col),
        .busy          (busy),
        .done          (done),
        .mem           (mif)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] sp0, sp1, sp2;
    logic [15:0] sram_xor = 16'h0;
    int          wb_src [64];
    logic [31:0] fetched [64];
    int          run_id = 0;

    // Memory models: SRAM returns a function of the address three cycles later; RAM reads in one cycle.
    always @(posedge CLOCK_50_I) begin
        sp0 <= mif.SRAM_address;
        sp1 <= sp0;
        sp2 <= sp1;
        mif.ram_read_data <= 32'(wb_src[mif.ram_address]);
        if (mif.ram_we)
            fetched[mif.ram_address] <= {16'(run_id), mif.ram_write_data};
    end
    assign mif.SRAM_read_data = sp2[15:0] ^ sram_xor;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int eff_plane(input logic [1:0] p);
        return (p == 2'd3) ? 0 : int'(p);
    endfunction

    function automatic int plane_w(input int p);
        return (p == 1 || p == 2) ? 160 : 320;
    endfunction

    function automatic int fetch_addr(input int p, input int row, input int col, input int k);
        int off;
        off = (p == 1) ? 76800 : (p == 2) ? 115200 : 0;
        return 76800 + off + (row * 8 + k / 8) * plane_w(p) + col * 8 + k % 8;
    endfunction

    function automatic int wb_addr(input int p, input int row, input int col, input int k);
        int base;
        base = (p == 1) ? 38400 : (p == 2) ? 57600 : 0;
        return base + (row * 8 + k / 8) * (plane_w(p) / 2) + col * 4 + (k % 8) / 2;
    endfunction

    function automatic int clip(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic rand_cmd(output logic [1:0] p, output int row, output int col);
        p   = 2'($urandom_range(0, 3));
        row = int'($urandom_range(0, 29));
        col = int'($urandom_range(0, (eff_plane(p) == 0) ? 39 : 19));
    endtask

    task automatic drive_noise();
        cmd_writeback = 1'($urandom);
        plane         = 2'($urandom);
        block_row     = 5'($urandom);
        block_col     = 6'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge CLOCK_50_I);
            chk("idle_busy", 32'(busy), 0);
            start = 1'b0;
        end
    endtask

    // Issue one command, watch it cycle by cycle, and compare against the model.
    task automatic run_cmd(input bit wb, input logic [1:0] pl, input int row, input int col,
                           input bit inject, input bit stray_done, input int abort_cyc);
        int          exp_a [64];
        logic [15:0] exp_d [32];
        int          ep, exp_done, done_cyc, busy_cnt, done_cnt, we_low, ram_we_cnt, widx, c;
        bit          fin;
        ep = eff_plane(pl);
        run_id++;
        for (int k = 0; k < 64; k++)
            exp_a[k] = wb ? wb_addr(ep, row, col, k) : fetch_addr(ep, row, col, k);
        for (int j = 0; j < 32; j++)
            exp_d[j] = {8'(clip(wb_src[2*j])), 8'(clip(wb_src[2*j+1]))};
        exp_done = wb ? 67 : 68;
        done_cyc = 0; busy_cnt = 0; done_cnt = 0; we_low = 0; ram_we_cnt = 0; widx = 0; c = 0;
        fin = 1'b0;

        @(negedge CLOCK_50_I);
        chk("start_busy", 32'(busy), 0);
        start         = 1'b1;
        cmd_writeback = wb;
        plane         = pl;
        block_row     = 5'(row);
        block_col     = 6'(col);

        while (!fin) begin
            @(negedge CLOCK_50_I);
            c++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (!wb && c <= 64)
                chk("f_addr", 32'(mif.SRAM_address), 32'(exp_a[c-1]));
            if (!mif.SRAM_we_n) begin
                if (wb && widx < 32) begin
                    chk("wb_addr", 32'(mif.SRAM_address), 32'(exp_a[2*widx]));
                    chk("wb_data", 32'(mif.SRAM_write_data), 32'(exp_d[widx]));
                    chk("wb_cyc", 32'(c), 32'(4 + 2 * widx));
                end
                if (wb) widx++;
                else we_low++;
            end
            if (mif.ram_we) begin
                ram_we_cnt++;
                if (!wb) chk("f_wr_cyc", 32'(c), 32'(mif.ram_address) + 32'd4);
            end
            if (abort_cyc != 0 && c == abort_cyc) begin
                start  = 1'b0;
                resetn = 1'b0;
                #1;
                chk("rst_we_n", 32'(mif.SRAM_we_n), 1);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_ram_we", 32'(mif.ram_we), 0);
                chk("rst_sram_addr", 32'(mif.SRAM_address), 0);
                chk("rst_state_idle", 32'(dut.state_q == S_IDLE), 1);
                @(negedge CLOCK_50_I);
                resetn = 1'b1;
                return;
            end
            if (done_cyc != 0 || c >= 200) fin = 1'b1;
            drive_noise();
            start = (stray_done && fin) || (inject && !fin && (c % 7 == 3));
        end

        chk("done_cyc", 32'(done_cyc), 32'(exp_done));
        chk("busy_cnt", 32'(busy_cnt), 32'(exp_done));
        chk("done_cnt", 32'(done_cnt), 1);
        if (wb) begin
            chk("wb_nwr", 32'(widx), 32);
            chk("wb_ram_we", 32'(ram_we_cnt), 0);
        end else begin
            chk("f_we_n_low", 32'(we_low), 0);
            chk("f_nwr", 32'(ram_we_cnt), 64);
            for (int k = 0; k < 64; k++)
                chk("f_ram", fetched[k], {16'(run_id), 16'(exp_a[k]) ^ sram_xor});
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] p;
        int         r, cl;

        resetn = 1'b0; start = 1'b0; cmd_writeback = 1'b0;
        plane = 2'd0; block_row = '0; block_col = '0;
        for (int k = 0; k < 64; k++) wb_src[k] = k;
        repeat (3) @(negedge CLOCK_50_I);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_we_n", 32'(mif.SRAM_we_n), 1);
        chk("reset_sram_addr", 32'(mif.SRAM_address), 0);
        chk("reset_sram_wdata", 32'(mif.SRAM_write_data), 0);
        chk("reset_ram_addr", 32'(mif.ram_address), 0);
        chk("reset_ram_we", 32'(mif.ram_we), 0);
        chk("reset_ram_wdata", 32'(mif.ram_write_data), 0);
        resetn = 1'b1;

        // Fetch Y (1,2), then a writeback of V (29,19) with RAM[k]=k started right after done.
        run_cmd(1'b0, 2'd0, 1, 2, 1'b0, 1'b0, 0);
        run_cmd(1'b1, 2'd2, 29, 19, 1'b0, 1'b0, 0);

        // Clipping boundaries around random signed data.
        for (int k = 0; k < 64; k++) wb_src[k] = int'($urandom_range(0, 1200)) - 600;
        wb_src[0] = -5; wb_src[1] = 300; wb_src[2] = 0; wb_src[3] = 255;
        rand_cmd(p, r, cl);
        run_cmd(1'b1, p, r, cl, 1'b0, 1'b0, 0);

        // Stray start strobes while busy, with different commands on the inputs.
        sram_xor = 16'($urandom);
        rand_cmd(p, r, cl);
        run_cmd(1'b0, p, r, cl, 1'b1, 1'b0, 0);
        rand_cmd(p, r, cl);
        run_cmd(1'b1, p, r, cl, 1'b1, 1'b0, 0);

        // Start in the done cycle must be ignored.
        rand_cmd(p, r, cl);
        run_cmd(1'b1, p, r, cl, 1'b0, 1'b1, 0);
        idle_cycles(3);

        // Reset in cycle 30 of a writeback, then a full fetch.
        rand_cmd(p, r, cl);
        run_cmd(1'b1, p, r, cl, 1'b0, 1'b0, 30);
        rand_cmd(p, r, cl);
        run_cmd(1'b0, p, r, cl, 1'b0, 1'b0, 0);

        // Plane code 3 behaves as Y.
        run_cmd(1'b0, 2'd3, 29, 39, 1'b0, 1'b0, 0);
        run_cmd(1'b1, 2'd3, 0, 0, 1'b0, 1'b0, 0);

        // Random mix.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 64; k++) wb_src[k] = int'($urandom_range(0, 1000)) - 300;
            sram_xor = 16'($urandom);
            rand_cmd(p, r, cl);
            run_cmd(1'($urandom), p, r, cl, 1'($urandom), 1'b0, 0);
        end

        idle_cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
